// File: rtl/taxi_arb_rr.sv
// Combinational round-robin priority select.
// Picks the first requester found scanning upward from last_grant+1, wrapping
// modulo PORTS. Reusable; holds no state (the caller keeps last_grant).
//   req        in   PORTS     request vector
//   last_grant in   CL_PORTS  index granted most recently
//   gnt_valid  out  1         at least one request present
//   gnt_idx    out  CL_PORTS  selected index (0 when gnt_valid=0)
module taxi_arb_rr #(
  parameter  int PORTS    = 2,
  localparam int CL_PORTS = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]    req,
  input  logic [CL_PORTS-1:0] last_grant,
  output logic                gnt_valid,
  output logic [CL_PORTS-1:0] gnt_idx
);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // Walk from the farthest offset to the nearest; the last hit (nearest to
    // last_grant+1) is the one that sticks.
    for (int i = PORTS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % PORTS;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CL_PORTS'(idx);
      end
    end
  end

endmodule

// File: rtl/taxi_eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter in front of a 1G MAC TX FIFO.
// One source owns the output for a whole frame; its index is packed into the
// low tid bits so TX completions can be steered back to it.
//   clk, rst              logic clock, synchronous active-high reset
//   s_axis_*  [PORTS]     per-source TX frame streams (sink)
//   m_axis_*              merged TX stream to the MAC (source)
//   s_axis_cpl_*          TX completions from the MAC (sink)
//   m_axis_cpl_* [PORTS]  per-source completion streams (source)
//   grant_valid/grant_idx current frame owner
//   cpl_err               1-cycle pulse when a completion tag >= PORTS is dropped
module taxi_eth_tx_frame_arb #(
  parameter  int PORTS    = 2,
  parameter  int DATA_W   = 8,
  parameter  int ID_W     = 8,
  parameter  int CPL_W    = 96,
  localparam int CL_PORTS = $clog2(PORTS),
  localparam int KEEP_W   = (DATA_W + 7) / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS-1:0][DATA_W-1:0]      s_axis_tdata,
  input  logic [PORTS-1:0][KEEP_W-1:0]      s_axis_tkeep,
  input  logic [PORTS-1:0]                  s_axis_tvalid,
  output logic [PORTS-1:0]                  s_axis_tready,
  input  logic [PORTS-1:0]                  s_axis_tlast,
  input  logic [PORTS-1:0][ID_W-1:0]        s_axis_tid,
  input  logic [PORTS-1:0]                  s_axis_tuser,
  output logic [DATA_W-1:0]                 m_axis_tdata,
  output logic [KEEP_W-1:0]                 m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [ID_W-1:0]                   m_axis_tid,
  output logic                              m_axis_tuser,
  input  logic [CPL_W-1:0]                  s_axis_cpl_tdata,
  input  logic [ID_W-1:0]                   s_axis_cpl_tid,
  input  logic                              s_axis_cpl_tvalid,
  output logic                              s_axis_cpl_tready,
  output logic [PORTS-1:0][CPL_W-1:0]       m_axis_cpl_tdata,
  output logic [PORTS-1:0][ID_W-1:0]        m_axis_cpl_tid,
  output logic [PORTS-1:0]                  m_axis_cpl_tvalid,
  input  logic [PORTS-1:0]                  m_axis_cpl_tready,
  output logic                              grant_valid,
  output logic [CL_PORTS-1:0]               grant_idx,
  output logic                              cpl_err
);

  localparam int BUS_W = DATA_W + KEEP_W + 1 + ID_W + 1;

  typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [CL_PORTS-1:0] last_grant, rr_idx;
  logic                rr_valid;

  logic [BUS_W-1:0]    in_bus, out_bus, skid_bus;
  logic [ID_W-1:0]     in_tid;
  logic                in_fire, in_last, out_vld, out_fire, skid_vld;

  taxi_arb_rr #(.PORTS(PORTS)) u_rr (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .gnt_valid  (rr_valid),
    .gnt_idx    (rr_idx)
  );

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (rr_valid) state_nxt = XFER;
      XFER: if (in_fire && in_last) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_grant  <= CL_PORTS'(PORTS - 1);
    end else if (state == ARB && rr_valid) begin
      grant_valid <= 1'b1;
      grant_idx   <= rr_idx;
    end else if (state == XFER && in_fire && in_last) begin
      last_grant  <= grant_idx;
      grant_valid <= 1'b0;
    end
  end

  // ---------------- data path ----------------
  // tready depends only on registers, so no combinational path from m_axis_tready.
  for (genvar i = 0; i < PORTS; i++) begin : g_rdy
    assign s_axis_tready[i] = (state == XFER) && !skid_vld && (grant_idx == CL_PORTS'(i));
  end

  assign in_last  = s_axis_tlast[grant_idx];
  assign in_fire  = (state == XFER) && !skid_vld && s_axis_tvalid[grant_idx];
  // Source tag in the low bits; upper source tid bits fall off the top.
  assign in_tid   = (s_axis_tid[grant_idx] << CL_PORTS) | ID_W'(grant_idx);
  assign in_bus   = {s_axis_tdata[grant_idx], s_axis_tkeep[grant_idx], in_last,
                     in_tid, s_axis_tuser[grant_idx]};
  assign out_fire = out_vld && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_bus  <= '0;
      skid_bus <= '0;
    end else if (!out_vld || out_fire) begin
      if (skid_vld) begin
        out_bus  <= skid_bus;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        out_bus  <= in_bus;
        out_vld  <= 1'b1;
      end else begin
        out_vld  <= 1'b0;
      end
    end else if (in_fire) begin
      // output stalled: park the beat accepted this cycle
      skid_bus <= in_bus;
      skid_vld <= 1'b1;
    end
  end

  assign m_axis_tvalid = out_vld;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = out_bus;

  // ---------------- completion demux ----------------
  logic [CL_PORTS-1:0] cpl_in_tag, cpl_tag;
  logic                cpl_in_bad, cpl_vld, cpl_in_fire, cpl_out_fire;
  logic [ID_W-1:0]     cpl_tid;
  logic [CPL_W-1:0]    cpl_data;

  assign cpl_in_tag        = s_axis_cpl_tid[CL_PORTS-1:0];
  assign cpl_in_bad        = int'(cpl_in_tag) >= PORTS;
  assign cpl_out_fire      = |(m_axis_cpl_tvalid & m_axis_cpl_tready);
  // Bad tags are swallowed regardless of the slice state.
  assign s_axis_cpl_tready = cpl_in_bad || !cpl_vld || cpl_out_fire;
  assign cpl_in_fire       = s_axis_cpl_tvalid && s_axis_cpl_tready;

  for (genvar i = 0; i < PORTS; i++) begin : g_cpl
    assign m_axis_cpl_tvalid[i] = cpl_vld && (cpl_tag == CL_PORTS'(i));
    assign m_axis_cpl_tdata[i]  = cpl_data;
    assign m_axis_cpl_tid[i]    = cpl_tid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_vld  <= 1'b0;
      cpl_tag  <= '0;
      cpl_tid  <= '0;
      cpl_data <= '0;
      cpl_err  <= 1'b0;
    end else begin
      cpl_err <= cpl_in_fire && cpl_in_bad;
      if (cpl_in_fire && !cpl_in_bad) begin
        cpl_vld  <= 1'b1;
        cpl_tag  <= cpl_in_tag;
        cpl_tid  <= s_axis_cpl_tid >> CL_PORTS;
        cpl_data <= s_axis_cpl_tdata;
      end else if (cpl_out_fire) begin
        cpl_vld  <= 1'b0;
      end
    end
  end

endmodule
